// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared definitions for the PS/2 scan-code decoder: set-2 byte constants,
// decoder state encoding and the queued key-event word layout.
package ps2_scancode_decoder_pkg;

    // Scan-code set 2 prefixes
    localparam logic [7:0] SC_E0       = 8'hE0;
    localparam logic [7:0] SC_F0       = 8'hF0;
    localparam logic [7:0] SC_E1       = 8'hE1;

    // Keyboard response bytes (only meaningful outside a prefix sequence)
    localparam logic [7:0] SC_ACK      = 8'hFA;
    localparam logic [7:0] SC_RESEND   = 8'hFE;
    localparam logic [7:0] SC_BAT_OK   = 8'hAA;
    localparam logic [7:0] SC_BAT_FAIL = 8'hFC;
    localparam logic [7:0] SC_ECHO     = 8'hEE;
    localparam logic [7:0] SC_ERR0     = 8'h00;
    localparam logic [7:0] SC_ERRF     = 8'hFF;

    // Pause is E1 followed by seven more bytes that carry no extra information
    localparam logic [2:0] PAUSE_LEN   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_E0    = 3'd1,
        ST_F0    = 3'd2,
        ST_E0F0  = 3'd3,
        ST_PAUSE = 3'd4
    } state_t;

    // Queued event word {ext, brk, code}; brk is the break (key release) flag
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

    // Key-detect error / overrun bytes abort any sequence
    function automatic logic is_err(input logic [7:0] b);
        return (b == SC_ERR0) || (b == SC_ERRF);
    endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Byte-stream input, event-queue output and keyboard response pulses of the
// scan-code decoder. The decoder uses the slave view, the CPU/host side the master view.
interface ps2_scancode_decoder_if #(
    parameter int FIFO_AW = 3
);
    logic [7:0]       rx_data;
    logic             rx_ready;
    logic [7:0]       evt_code;
    logic             evt_ext;
    logic             evt_release;
    logic             evt_valid;
    logic             evt_ack;
    logic [FIFO_AW:0] evt_count;
    logic             overflow;
    logic             clr_overflow;
    logic             kbd_ack;
    logic             kbd_resend;
    logic             kbd_bat_ok;
    logic             kbd_bat_fail;
    logic             kbd_echo;
    logic             kbd_err;

    modport slave (
        input  rx_data, rx_ready, evt_ack, clr_overflow,
        output evt_code, evt_ext, evt_release, evt_valid, evt_count, overflow,
        output kbd_ack, kbd_resend, kbd_bat_ok, kbd_bat_fail, kbd_echo, kbd_err
    );

    modport master (
        output rx_data, rx_ready, evt_ack, clr_overflow,
        input  evt_code, evt_ext, evt_release, evt_valid, evt_count, overflow,
        input  kbd_ack, kbd_resend, kbd_bat_ok, kbd_bat_fail, kbd_echo, kbd_err
    );
endinterface

// File: rtl/ps2_event_fifo.sv
// Show-ahead synchronous FIFO for 10-bit key events. A push while full is
// accepted only when a pop happens in the same cycle; the head reads as zero when empty.
module ps2_event_fifo #(
    parameter int AW = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [9:0]  wr_data,
    input  logic        pop,
    output logic [9:0]  rd_data,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);
    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [9:0]    mem [0:DEPTH-1];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign count   = count_reg;
    assign rd_data = empty ? 10'd0 : mem[rd_ptr_reg];

    // Storage write; contents need no reset because the head is masked while empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at 2**AW
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Scan-code set 2 decoder: folds E0/F0/E1 prefix sequences into single key
// events queued in a FIFO, and turns keyboard response bytes into one-cycle pulses.
module ps2_scancode_decoder
    import ps2_scancode_decoder_pkg::*;
#(
    parameter int FIFO_AW = 3,
    parameter int TO_W    = 20
) (
    input logic                   clk,
    input logic                   rst_n,
    ps2_scancode_decoder_if.slave bus
);
    // Timeout fires on the idle cycle that would bring the counter to all-ones
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    state_t          state_reg, state_next;
    logic [2:0]      pause_cnt_reg, pause_cnt_next;
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic            timeout;

    logic            push;
    evt_t            push_evt;
    evt_t            head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop_req;
    logic            overflow_reg;

    // Pulse order: ack, resend, bat_ok, bat_fail, echo, err
    logic [5:0]      kbd_next;
    logic [5:0]      kbd_reg;

    logic [7:0]      b;
    assign b = bus.rx_data;

    assign timeout = (state_reg != ST_IDLE) && !bus.rx_ready && (to_cnt_reg == TO_LAST);
    assign pop_req = bus.evt_ack & ~fifo_empty;

    // State, pause counter and timeout counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            pause_cnt_reg <= '0;
            to_cnt_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            pause_cnt_reg <= pause_cnt_next;
            to_cnt_reg    <= to_cnt_next;
        end
    end

    // Next-state logic: prefix tracking, Pause byte swallowing and timeout abort
    always_comb begin
        state_next     = state_reg;
        pause_cnt_next = pause_cnt_reg;
        if (bus.rx_ready) begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (b == SC_E0) begin
                        state_next = ST_E0;
                    end else if (b == SC_F0) begin
                        state_next = ST_F0;
                    end else if (b == SC_E1) begin
                        state_next     = ST_PAUSE;
                        pause_cnt_next = PAUSE_LEN;
                    end
                end
                ST_E0: begin
                    if (b == SC_F0)      state_next = ST_E0F0;
                    else if (b == SC_E0) state_next = ST_E0;
                    else                 state_next = ST_IDLE;
                end
                ST_F0, ST_E0F0: begin
                    state_next = ST_IDLE;
                end
                ST_PAUSE: begin
                    pause_cnt_next = pause_cnt_reg - 3'd1;
                    if (pause_cnt_reg == 3'd1) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end else if (timeout) begin
            state_next = ST_IDLE;
        end
        // Counter only runs while a sequence is open and the keyboard is silent
        if (state_reg == ST_IDLE || bus.rx_ready || timeout) begin
            to_cnt_next = '0;
        end else begin
            to_cnt_next = to_cnt_reg + TO_W'(1);
        end
    end

    // Output decode: FIFO push word and response pulses for the current byte
    always_comb begin
        push     = 1'b0;
        push_evt = '0;
        kbd_next = '0;
        if (bus.rx_ready) begin
            unique case (state_reg)
                ST_IDLE: begin
                    case (b)
                        SC_E0, SC_F0, SC_E1: ;
                        SC_ACK:              kbd_next[5] = 1'b1;
                        SC_RESEND:           kbd_next[4] = 1'b1;
                        SC_BAT_OK:           kbd_next[3] = 1'b1;
                        SC_BAT_FAIL:         kbd_next[2] = 1'b1;
                        SC_ECHO:             kbd_next[1] = 1'b1;
                        SC_ERR0, SC_ERRF:    kbd_next[0] = 1'b1;
                        default: begin
                            push     = 1'b1;
                            push_evt = '{ext: 1'b0, brk: 1'b0, code: b};
                        end
                    endcase
                end
                ST_E0: begin
                    if (b == SC_F0 || b == SC_E0) begin
                        push = 1'b0;
                    end else if (is_err(b)) begin
                        kbd_next[0] = 1'b1;
                    end else begin
                        push     = 1'b1;
                        push_evt = '{ext: 1'b1, brk: 1'b0, code: b};
                    end
                end
                ST_F0, ST_E0F0: begin
                    if (is_err(b)) begin
                        kbd_next[0] = 1'b1;
                    end else begin
                        push     = 1'b1;
                        push_evt = '{ext: (state_reg == ST_E0F0), brk: 1'b1, code: b};
                    end
                end
                ST_PAUSE: begin
                    if (pause_cnt_reg == 3'd1) begin
                        push     = 1'b1;
                        push_evt = '{ext: 1'b0, brk: 1'b0, code: SC_E1};
                    end
                end
                default: push = 1'b0;
            endcase
        end
    end

    // Response pulses are registered so each lasts exactly one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) kbd_reg <= '0;
        else        kbd_reg <= kbd_next;
    end

    // Sticky overflow: a dropped event wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                overflow_reg <= 1'b0;
        else if (push && fifo_full && !pop_req)    overflow_reg <= 1'b1;
        else if (bus.clr_overflow)                 overflow_reg <= 1'b0;
    end

    ps2_event_fifo #(
        .AW(FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (push_evt),
        .pop     (bus.evt_ack),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (bus.evt_count)
    );

    assign bus.evt_code     = head.code;
    assign bus.evt_ext      = head.ext;
    assign bus.evt_release  = head.brk;
    assign bus.evt_valid    = ~fifo_empty;
    assign bus.overflow     = overflow_reg;
    assign bus.kbd_ack      = kbd_reg[5];
    assign bus.kbd_resend   = kbd_reg[4];
    assign bus.kbd_bat_ok   = kbd_reg[3];
    assign bus.kbd_bat_fail = kbd_reg[2];
    assign bus.kbd_echo     = kbd_reg[1];
    assign bus.kbd_err      = kbd_reg[0];

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for the PS/2 scan-code decoder (short timeout width so the
// prefix-timeout boundary is reachable quickly).
module tb_ps2_scancode_decoder;

    localparam int FIFO_AW = 3;
    localparam int TO_W    = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    ps2_scancode_decoder_if #(.FIFO_AW(FIFO_AW)) bus ();

    ps2_scancode_decoder #(
        .FIFO_AW (FIFO_AW),
        .TO_W    (TO_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        bus.rx_data  = v;
        bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
    endtask

    function automatic logic [5:0] kbd_vec();
        return {bus.kbd_ack, bus.kbd_resend, bus.kbd_bat_ok,
                bus.kbd_bat_fail, bus.kbd_echo, bus.kbd_err};
    endfunction

    function automatic logic [9:0] head_vec();
        return {bus.evt_ext, bus.evt_release, bus.evt_code};
    endfunction

    task automatic pop_expect(input string tag, input logic [9:0] exp);
        check({tag, "_valid"}, 32'(bus.evt_valid), 32'd1);
        check(tag, 32'(head_vec()), 32'(exp));
        bus.evt_ack = 1'b1;
        tick();
        bus.evt_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rsp_byte [7];
        logic [5:0] rsp_mask [7];
        rsp_byte = '{8'hFA, 8'hAA, 8'hFE, 8'hEE, 8'hFC, 8'h00, 8'hFF};
        rsp_mask = '{6'b100000, 6'b001000, 6'b010000, 6'b000010,
                     6'b000100, 6'b000001, 6'b000001};

        bus.rx_data      = 8'h00;
        bus.rx_ready     = 1'b0;
        bus.evt_ack      = 1'b0;
        bus.clr_overflow = 1'b0;
        tick();
        tick();
        // Reset state
        check("rst_valid", 32'(bus.evt_valid), 32'd0);
        check("rst_count", 32'(bus.evt_count), 32'd0);
        check("rst_head", 32'(head_vec()), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        check("rst_kbd", 32'(kbd_vec()), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: make and break of a plain key
        send_byte(8'h1C);
        check("t1_valid_lat", 32'(bus.evt_valid), 32'd1);
        send_byte(8'hF0);
        send_byte(8'h1C);
        check("t1_count", 32'(bus.evt_count), 32'd2);
        pop_expect("t1_make", 10'h01C);
        pop_expect("t1_break", 10'h11C);
        check("t1_empty", 32'(bus.evt_valid), 32'd0);

        // 2: extended make/break, then Pause
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0);
        check("t2_pause_pending", 32'(bus.evt_count), 32'd2);
        send_byte(8'h77);
        check("t2_count", 32'(bus.evt_count), 32'd3);
        pop_expect("t2_ext_make", 10'h275);
        pop_expect("t2_ext_break", 10'h375);
        pop_expect("t2_pause", 10'h0E1);

        // 3: keyboard responses in IDLE are pulses, never events
        for (int i = 0; i < 7; i++) begin
            send_byte(rsp_byte[i]);
            check($sformatf("t3_pulse_%02h", rsp_byte[i]), 32'(kbd_vec()), 32'(rsp_mask[i]));
            tick();
            check($sformatf("t3_clear_%02h", rsp_byte[i]), 32'(kbd_vec()), 32'd0);
        end
        check("t3_count", 32'(bus.evt_count), 32'd0);
        send_byte(8'hE0);
        send_byte(8'hFA);
        check("t3_e0fa_noack", 32'(kbd_vec()), 32'd0);
        pop_expect("t3_e0fa", 10'h2FA);
        send_byte(8'hF0);
        send_byte(8'hFF);
        check("t3_f0ff_err", 32'(kbd_vec()), 32'd1);
        check("t3_f0ff_noevt", 32'(bus.evt_count), 32'd0);

        // 4: overflow, clear priority, push+pop while full
        for (int i = 1; i <= 9; i++) send_byte(8'(i));
        check("t4_count_full", 32'(bus.evt_count), 32'd8);
        check("t4_ovf_set", 32'(bus.overflow), 32'd1);
        bus.clr_overflow = 1'b1;
        tick();
        bus.clr_overflow = 1'b0;
        check("t4_ovf_clr", 32'(bus.overflow), 32'd0);
        bus.clr_overflow = 1'b1;
        send_byte(8'h0B);
        bus.clr_overflow = 1'b0;
        check("t4_set_wins", 32'(bus.overflow), 32'd1);
        bus.evt_ack = 1'b1;
        send_byte(8'h0A);
        bus.evt_ack = 1'b0;
        check("t4_pushpop_count", 32'(bus.evt_count), 32'd8);
        check("t4_pushpop_ovf", 32'(bus.overflow), 32'd1);
        for (int i = 2; i <= 8; i++) pop_expect($sformatf("t4_pop_%0d", i), 10'(i));
        pop_expect("t4_pop_last", 10'h00A);
        bus.evt_ack = 1'b1;
        tick();
        bus.evt_ack = 1'b0;
        check("t4_ack_empty", 32'(bus.evt_count), 32'd0);
        bus.clr_overflow = 1'b1;
        tick();
        bus.clr_overflow = 1'b0;

        // 5: prefix timeout boundary
        send_byte(8'hE0);
        repeat ((1 << TO_W) - 2) tick();
        send_byte(8'h1C);
        pop_expect("t5_before_to", 10'h21C);
        send_byte(8'hE0);
        repeat ((1 << TO_W) - 1) tick();
        send_byte(8'h1C);
        pop_expect("t5_after_to", 10'h01C);

        // 6: asynchronous reset mid-sequence
        send_byte(8'h1C); send_byte(8'h1D); send_byte(8'h1E);
        send_byte(8'hF0);
        check("t6_pre_count", 32'(bus.evt_count), 32'd3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(bus.evt_valid), 32'd0);
        check("t6_rst_count", 32'(bus.evt_count), 32'd0);
        check("t6_rst_head", 32'(head_vec()), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send_byte(8'h1C);
        pop_expect("t6_after_rst", 10'h01C);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
